avm_master: RTL
===============

AVM_MASTER -- requirements
Module: avm_master

Interface
REQ-001 Parameter READ_LATENCY, default 1, meaning cycles from read acceptance (waitrequest low) to valid avm_readdata_i; legal range 1..4.
REQ-002 Parameter TIMEOUT, default 255, meaning max consecutive waitrequest-high cycles before abort; 0 disables timeout; legal range 0..255.
REQ-003 Ports: clk_i  in  1  single clock, all logic on rising edge.
REQ-004 Ports: srst_i  in  1  reset, synchronous, active-high.
REQ-005 Ports: cmd_valid_i  in  1  command request.
REQ-006 Ports: cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
REQ-007 Ports: cmd_write_i  in  1  1=write, 0=read.
REQ-008 Ports: cmd_address_i  in  4  register address.
REQ-009 Ports: cmd_writedata_i  in  8  write byte.
REQ-010 Ports: rsp_valid_o  out  1  one-cycle response pulse, no backpressure.
REQ-011 Ports: rsp_readdata_o  out  8  read byte; 0 for writes and timeouts.
REQ-012 Ports: rsp_timeout_o  out  1  qualifies rsp_valid_o; transaction aborted.
REQ-013 Ports: avm_address_o  out  4, avm_read_o  out  1, avm_write_o  out  1, avm_writedata_o  out  8  Avalon-MM host request.
REQ-014 Ports: avm_readdata_i  in  8, avm_waitrequest_i  in  1  Avalon-MM agent response.

Function
REQ-015 FSM states: IDLE, ACCESS, RDWAIT, RESP; all outputs registered.
REQ-016 cmd_ready_o SHALL be high only in IDLE; command captured on edge where cmd_valid_i and cmd_ready_o are high; FSM -> ACCESS.
REQ-017 In ACCESS, avm_address_o/avm_writedata_o SHALL hold captured values and exactly one of avm_read_o/avm_write_o SHALL be high.
REQ-018 Strobe and address/data SHALL stay constant while avm_waitrequest_i is high.
REQ-019 On an ACCESS cycle with avm_waitrequest_i low, strobe deasserts next edge; write -> RESP, read -> RDWAIT (counter loaded).
REQ-020 RDWAIT: avm_readdata_i sampled on the READ_LATENCY-th cycle after the accepting cycle (READ_LATENCY=1: the cycle immediately after); sample lands in rsp_readdata_o and FSM -> RESP on that edge.
REQ-021 RESP: rsp_valid_o high exactly one cycle, then IDLE; rsp_readdata_o/rsp_timeout_o valid only while rsp_valid_o high, 0 otherwise.
REQ-022 Latency, zero wait: accept edge T0; strobe in cycle T1; write pulse in T2; read pulse in T1+READ_LATENCY+1.
REQ-023 Timeout: wait counter increments each ACCESS cycle with waitrequest high; on reaching TIMEOUT (non-zero) strobe drops next edge, FSM -> RESP with rsp_timeout_o=1, rsp_readdata_o=0.
REQ-024 Waitrequest low on the same cycle the counter reaches TIMEOUT SHALL complete normally (no timeout).
REQ-025 Every accepted command SHALL produce exactly one response; no command accepted between acceptance and its response.
REQ-026 Addresses 4..15 SHALL be issued unchanged; no address filtering.
REQ-027 avm_read_o and avm_write_o SHALL never be high simultaneously.

Reset
REQ-028 srst_i high at an edge: FSM -> IDLE; cmd_ready_o=1 after reset release; all other outputs 0; counters 0.
REQ-029 Reset mid-transaction SHALL drop strobes at that edge and discard the pending response.

Structure
REQ-030 Shared package avm_pkg: state enum, ADDR_W=4, DATA_W=8, UART register address constants (TXDATA=0, STATUS=1, REG2=2, REG3=3).
REQ-031 One sub-module avm_wait_timer: loadable 8-bit down/up counter serving read-latency and timeout counting.

Verification
REQ-032 Write addr 0 data 0x5A, waitrequest low -> avm_write_o one cycle with 0x5A at addr 0; rsp_valid_o pulse 2 cycles after accept, timeout 0.
REQ-033 Read addr 1, READ_LATENCY=1, agent returns 0x01 -> rsp_readdata_o=0x01 with pulse 3 cycles after accept.
REQ-034 Read addr 2, waitrequest high 5 cycles -> strobe/address stable 6 cycles; response follows per REQ-020.
REQ-035 TIMEOUT=4, waitrequest stuck high -> strobe 4 cycles then drops; rsp_timeout_o=1, rsp_readdata_o=0.
REQ-036 cmd_valid_i held high for 3 writes -> each accepted only in IDLE, 3 responses, writes spaced 3 cycles.
REQ-037 srst_i asserted during RDWAIT -> no rsp_valid_o, strobes 0, cmd_ready_o=1 first cycle after release.

Source files
------------

// File: rtl/avm_pkg.sv
// Shared definitions for the Avalon-MM command master: widths, FSM states,
// UART register map and a small counter helper.
package avm_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  localparam logic [ADDR_W-1:0] UART_TXDATA = 4'd0;
  localparam logic [ADDR_W-1:0] UART_STATUS = 4'd1;
  localparam logic [ADDR_W-1:0] UART_REG2   = 4'd2;
  localparam logic [ADDR_W-1:0] UART_REG3   = 4'd3;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RDWAIT,
    RESP
  } state_e;

  // Terminal count for an n-cycle window counted from zero; 0 maps to 0.
  function automatic logic [CNT_W-1:0] cnt_last(input int unsigned n);
    if (n == 0) begin
      return '0;
    end
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/avm_wait_timer.sv
// Loadable 8-bit counter: counts up waitrequest cycles for the timeout and
// counts down the read-latency window.
module avm_wait_timer
  import avm_pkg::*;
(
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  // Saturating in both directions so a disabled timeout never wraps.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 8'd1;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/avm_master.sv
// Single-outstanding Avalon-MM host: takes one command, runs one bus access
// with optional waitrequest timeout, and returns a one-cycle response pulse.
module avm_master
  import avm_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_address_i,
  input  logic [DATA_W-1:0] cmd_writedata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_readdata_o,
  output logic              rsp_timeout_o,
  output logic [ADDR_W-1:0] avm_address_o,
  output logic              avm_read_o,
  output logic              avm_write_o,
  output logic [DATA_W-1:0] avm_writedata_o,
  input  logic [DATA_W-1:0] avm_readdata_i,
  input  logic              avm_waitrequest_i
);

  localparam logic [CNT_W-1:0] RD_LOAD  = cnt_last(READ_LATENCY);
  localparam logic [CNT_W-1:0] TMO_LAST = cnt_last(TIMEOUT);
  localparam bit               TMO_EN   = (TIMEOUT != 0);

  state_e            state_d, state_q;
  logic              cmd_ready_d, cmd_ready_q;
  logic              rsp_valid_d, rsp_valid_q;
  logic [DATA_W-1:0] rsp_readdata_d, rsp_readdata_q;
  logic              rsp_timeout_d, rsp_timeout_q;
  logic [ADDR_W-1:0] avm_address_d, avm_address_q;
  logic              avm_read_d, avm_read_q;
  logic              avm_write_d, avm_write_q;
  logic [DATA_W-1:0] avm_writedata_d, avm_writedata_q;

  logic              tmr_clr, tmr_load, tmr_inc, tmr_dec;
  logic [CNT_W-1:0]  tmr_count;
  logic              tmr_zero;

  avm_wait_timer u_timer (
    .clk_i      (clk_i),
    .srst_i     (srst_i),
    .clr_i      (tmr_clr),
    .load_i     (tmr_load),
    .load_val_i (RD_LOAD),
    .inc_i      (tmr_inc),
    .dec_i      (tmr_dec),
    .count_o    (tmr_count),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d         = state_q;
    rsp_valid_d     = 1'b0;
    rsp_readdata_d  = '0;
    rsp_timeout_d   = 1'b0;
    avm_address_d   = avm_address_q;
    avm_read_d      = avm_read_q;
    avm_write_d     = avm_write_q;
    avm_writedata_d = avm_writedata_q;
    tmr_clr         = 1'b0;
    tmr_load        = 1'b0;
    tmr_inc         = 1'b0;
    tmr_dec         = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          state_d         = ACCESS;
          avm_address_d   = cmd_address_i;
          avm_writedata_d = cmd_writedata_i;
          avm_write_d     = cmd_write_i;
          avm_read_d      = ~cmd_write_i;
          tmr_clr         = 1'b1;
        end
      end

      // A low waitrequest always wins, even on the cycle the timeout expires.
      ACCESS: begin
        if (!avm_waitrequest_i) begin
          avm_read_d  = 1'b0;
          avm_write_d = 1'b0;
          if (avm_write_q) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
          end else begin
            state_d  = RDWAIT;
            tmr_load = 1'b1;
          end
        end else if (TMO_EN && (tmr_count == TMO_LAST)) begin
          avm_read_d    = 1'b0;
          avm_write_d   = 1'b0;
          state_d       = RESP;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end

      RDWAIT: begin
        if (tmr_zero) begin
          state_d        = RESP;
          rsp_valid_d    = 1'b1;
          rsp_readdata_d = avm_readdata_i;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d     = IDLE;
        avm_read_d  = 1'b0;
        avm_write_d = 1'b0;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q         <= IDLE;
      cmd_ready_q     <= 1'b1;
      rsp_valid_q     <= 1'b0;
      rsp_readdata_q  <= '0;
      rsp_timeout_q   <= 1'b0;
      avm_address_q   <= '0;
      avm_read_q      <= 1'b0;
      avm_write_q     <= 1'b0;
      avm_writedata_q <= '0;
    end else begin
      state_q         <= state_d;
      cmd_ready_q     <= cmd_ready_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_readdata_q  <= rsp_readdata_d;
      rsp_timeout_q   <= rsp_timeout_d;
      avm_address_q   <= avm_address_d;
      avm_read_q      <= avm_read_d;
      avm_write_q     <= avm_write_d;
      avm_writedata_q <= avm_writedata_d;
    end
  end

  assign cmd_ready_o     = cmd_ready_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_readdata_o  = rsp_readdata_q;
  assign rsp_timeout_o   = rsp_timeout_q;
  assign avm_address_o   = avm_address_q;
  assign avm_read_o      = avm_read_q;
  assign avm_write_o     = avm_write_q;
  assign avm_writedata_o = avm_writedata_q;

endmodule
